// File: rtl/jk_grant_arbiter_if.sv
// Request/release and grant status bundle shared between requesters and the arbiter.
interface jk_grant_arbiter_if #(
    parameter int N  = 4,
    parameter int OW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  grant;
    logic          busy;
    logic [OW-1:0] owner;
    logic          timeout;

    modport master (output req, done, input grant, busy, owner, timeout);
    modport slave  (input req, done, output grant, busy, owner, timeout);
endinterface

// File: rtl/jk_grant_arbiter.sv
// Round-robin arbiter for one set/clear resource, with a hold watchdog that
// reclaims the grant from an owner that never pulses done.
module jk_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int OW       = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    jk_grant_arbiter_if.slave bus
);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    logic          pick_valid;
    logic [OW-1:0] pick_idx;

    // Rotating scan starting just after the previous winner.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_q) + i) % N;
            if (!pick_valid && bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                // done takes priority over a watchdog expiry on the same edge.
                if (bus.done[owner_q]) begin
                    state_d = S_GAP;
                    owner_d = '0;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                    state_d   = S_GAP;
                    owner_d   = '0;
                    timeout_d = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            last_q    <= OW'(N - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = (state_q == S_GRANT) ? (N'(1) << owner_q) : '0;
    assign bus.busy    = (state_q == S_GRANT);
    assign bus.owner   = owner_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_jk_grant_arbiter.sv
// Directed bench for jk_grant_arbiter: one instance with the watchdog, one without.
module tb_jk_grant_arbiter;
    logic clk;
    logic reset;
    logic reset_nh;
    int   n_checks;
    int   n_errors;

    jk_grant_arbiter_if #(.N(4)) ia ();
    jk_grant_arbiter_if #(.N(4)) ib ();

    jk_grant_arbiter #(.N(4), .MAX_HOLD(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    jk_grant_arbiter #(.N(4), .MAX_HOLD(0)) u_dut_nohold (
        .clk   (clk),
        .reset (reset_nh),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ia.req  = 4'b0000;
        ia.done = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " grant"}, 32'(ia.grant), 32'h0);
        check_val({tag, " busy"}, 32'(ia.busy), 32'h0);
        check_val({tag, " owner"}, 32'(ia.owner), 32'h0);
    endtask

    logic [3:0] exp_seq [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        reset_nh = 1'b1;
        ia.req   = 4'b0000;
        ia.done  = 4'b0000;
        ib.req   = 4'b0000;
        ib.done  = 4'b0000;
        exp_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: reset, then first grant
        tick();
        tick();
        check_idle("reset");
        check_val("reset timeout", 32'(ia.timeout), 32'h0);
        reset  = 1'b0;
        ia.req = 4'b0101;
        tick();
        check_val("first grant", 32'(ia.grant), 32'h1);
        check_val("first owner", 32'(ia.owner), 32'h0);
        check_val("first busy", 32'(ia.busy), 32'h1);
        ia.done = 4'b0001;
        tick();
        check_idle("first gap");
        ia.done = 4'b0000;
        tick();
        tick();
        check_val("second grant", 32'(ia.grant), 32'h4);
        check_val("second owner", 32'(ia.owner), 32'h2);

        // 2: round-robin with immediate release
        do_reset();
        ia.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_val("rr grant", 32'(ia.grant), 32'(exp_seq[k]));
            check_val("rr timeout", 32'(ia.timeout), 32'h0);
            ia.done = exp_seq[k];
            tick();
            check_idle("rr gap");
            check_val("rr gap timeout", 32'(ia.timeout), 32'h0);
            ia.done = 4'b0000;
            tick();
            check_idle("rr idle");
            tick();
        end

        // 3: watchdog
        do_reset();
        ia.req = 4'b0010;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check_val("wd hold grant", 32'(ia.grant), 32'h2);
            check_val("wd hold timeout", 32'(ia.timeout), 32'h0);
            tick();
        end
        check_val("wd gap grant", 32'(ia.grant), 32'h0);
        check_val("wd gap timeout", 32'(ia.timeout), 32'h1);
        tick();
        check_idle("wd idle");
        check_val("wd idle timeout", 32'(ia.timeout), 32'h0);
        tick();
        check_val("wd regrant", 32'(ia.grant), 32'h2);

        // 4: non-owner done and dropped req are ignored
        do_reset();
        ia.req = 4'b0100;
        tick();
        check_val("ign owner", 32'(ia.owner), 32'h2);
        ia.done = 4'b1011;
        ia.req  = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("ign hold", 32'(ia.grant), 32'h4);
        end
        ia.done = 4'b0100;
        tick();
        check_val("ign release", 32'(ia.grant), 32'h0);
        check_val("ign release timeout", 32'(ia.timeout), 32'h0);
        ia.done = 4'b0000;

        // 5: done coincides with watchdog expiry
        do_reset();
        ia.req = 4'b0001;
        tick();
        for (int c = 0; c < 7; c++) tick();
        check_val("sim cycle8 grant", 32'(ia.grant), 32'h1);
        ia.done = 4'b0001;
        tick();
        check_val("sim gap grant", 32'(ia.grant), 32'h0);
        check_val("sim gap timeout", 32'(ia.timeout), 32'h0);
        ia.done = 4'b0000;
        ia.req  = 4'b0000;

        // 6a: reset mid-grant
        do_reset();
        ia.req = 4'b1111;
        tick();
        ia.done = 4'b0001;
        tick();
        ia.done = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check_val("mid owner", 32'(ia.owner), 32'h1);
        check_val("mid grant", 32'(ia.grant), 32'h2);
        reset = 1'b1;
        tick();
        check_idle("mid reset");
        check_val("mid reset timeout", 32'(ia.timeout), 32'h0);
        reset = 1'b0;
        tick();
        check_val("post reset grant", 32'(ia.grant), 32'h1);
        check_val("post reset owner", 32'(ia.owner), 32'h0);
        ia.req = 4'b0000;

        // 6b: watchdog disabled holds indefinitely
        tick();
        reset_nh = 1'b0;
        ib.req   = 4'b0100;
        tick();
        for (int c = 0; c < 100; c++) begin
            check_val("nohold grant", 32'(ib.grant), 32'h4);
            check_val("nohold timeout", 32'(ib.timeout), 32'h0);
            tick();
        end
        ib.done = 4'b0100;
        tick();
        check_val("nohold release", 32'(ib.grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end
endmodule
